// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped 2-bit counters with tagged targets, trained from Execute.
// Optional performance counters are enabled by defining BP_PERF_EN.
module branch_predictor #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned INDEX_WIDTH = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic [1:0]      BranchOpE,
  input  logic [XLEN-1:0] PCE,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  output logic            MispredictE,
  output logic [XLEN-1:0] CorrectPCE
`ifdef BP_PERF_EN
  ,
  output logic [31:0]     BranchCount,
  output logic [31:0]     MispredictCount
`endif
);

  localparam int unsigned TagW    = XLEN - INDEX_WIDTH - 2;
  localparam int unsigned Entries = 2 ** INDEX_WIDTH;

  logic [Entries-1:0] r_valid;
  logic [TagW-1:0]    r_tag    [Entries];
  logic [1:0]         r_ctr    [Entries];
  logic [XLEN-1:0]    r_target [Entries];

  logic [INDEX_WIDTH-1:0] w_idx_f, w_idx_e;
  logic [TagW-1:0]        w_tag_f, w_tag_e;
  logic                   w_hit_f, w_hit_e;
  logic                   w_is_br;
  logic                   w_set_valid, w_clr_valid, w_tag_we, w_ctr_we, w_tgt_we;
  logic [1:0]             w_ctr_cur, w_ctr_d;
  logic                   w_unused;

  assign w_unused = ^{PCF[1:0], PCE[1:0]};

  assign w_idx_f = PCF[INDEX_WIDTH+1:2];
  assign w_tag_f = PCF[XLEN-1:INDEX_WIDTH+2];
  assign w_idx_e = PCE[INDEX_WIDTH+1:2];
  assign w_tag_e = PCE[XLEN-1:INDEX_WIDTH+2];

  assign w_hit_f = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
  assign w_hit_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);

  assign PredTakenF  = w_hit_f && r_ctr[w_idx_f][1];
  assign PredTargetF = PredTakenF ? r_target[w_idx_f] : '0;

  assign w_is_br = (BranchOpE == 2'b01) || (BranchOpE == 2'b10);

  always_comb begin
    MispredictE = PredTakenE;
    if (w_is_br) begin
      MispredictE = (PCSrcE != PredTakenE) ||
                    (PCSrcE && PredTakenE && (PredTargetE != PCTargetE));
    end
  end

  assign CorrectPCE = PCSrcE ? PCTargetE : (PCE + XLEN'(4));

  assign w_ctr_cur = r_ctr[w_idx_e];

  always_comb begin
    w_set_valid = 1'b0;
    w_clr_valid = 1'b0;
    w_tag_we    = 1'b0;
    w_ctr_we    = 1'b0;
    w_tgt_we    = 1'b0;
    w_ctr_d     = w_ctr_cur;
    case (BranchOpE)
      2'b10: begin
        if (w_hit_e) begin
          w_ctr_we = 1'b1;
          if (PCSrcE) begin
            w_ctr_d  = (w_ctr_cur == 2'b11) ? 2'b11 : w_ctr_cur + 2'd1;
            w_tgt_we = 1'b1;
          end else begin
            w_ctr_d = (w_ctr_cur == 2'b00) ? 2'b00 : w_ctr_cur - 2'd1;
          end
        end else if (PCSrcE) begin
          w_set_valid = 1'b1;
          w_tag_we    = 1'b1;
          w_ctr_we    = 1'b1;
          w_ctr_d     = 2'b10;
          w_tgt_we    = 1'b1;
        end
      end
      2'b01: begin
        w_set_valid = 1'b1;
        w_tag_we    = 1'b1;
        w_ctr_we    = 1'b1;
        w_ctr_d     = 2'b11;
        w_tgt_we    = 1'b1;
      end
      default: begin
        // A non-branch that hits means the entry is stale (code changed or aliasing).
        w_clr_valid = w_hit_e;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
    end else if (w_set_valid) begin
      r_valid[w_idx_e] <= 1'b1;
    end else if (w_clr_valid) begin
      r_valid[w_idx_e] <= 1'b0;
    end
  end

  // Payload is qualified by r_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_tag_we) r_tag[w_idx_e] <= w_tag_e;
    if (w_ctr_we) r_ctr[w_idx_e] <= w_ctr_d;
    if (w_tgt_we) r_target[w_idx_e] <= PCTargetE;
  end

`ifdef BP_PERF_EN
  logic [31:0] r_branch_cnt, r_mispred_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_is_br)     r_branch_cnt  <= r_branch_cnt + 32'd1;
      if (MispredictE) r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign BranchCount     = r_branch_cnt;
  assign MispredictCount = r_mispred_cnt;
`endif

endmodule
